// File: rtl/m_ext_pkg.sv
// Shared M-extension / PCPI definitions: datapath width, initiator states, timeout default.
package m_ext_pkg;

    localparam int XLEN                        = 32;
    localparam int PCPI_TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } pcpi_init_state_t;

endpackage

// File: rtl/pcp_if.sv
// PCPI bus between the core-side initiator (Master) and a coprocessor (Slave).
interface PCP #(
    parameter int XLEN = m_ext_pkg::XLEN
);
    logic            valid;
    logic [31:0]     instruction;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            wr;
    logic [XLEN-1:0] rd;
    logic            busy;
    logic            ready;

    modport Master (
        output valid, instruction, rs1, rs2,
        input  wr, rd, busy, ready
    );

    modport Slave (
        input  valid, instruction, rs1, rs2,
        output wr, rd, busy, ready
    );
endinterface

// File: rtl/pcpi_watchdog.sv
// Issue timeout down-counter; only built when PCPI_INITIATOR_TIMEOUT_EN is defined.
`ifdef PCPI_INITIATOR_TIMEOUT_EN
module pcpi_watchdog
    import m_ext_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(TIMEOUT_CYCLES);
        end else if (count_en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // Fires during the last allowed counting cycle so the abort lands exactly on it.
    assign expired = count_en && (count == CW'(1));
endmodule
`endif

// File: rtl/pcpi_initiator.sv
// Core-side PCPI initiator: issues one instruction, waits for ready, reports result.
// Optional issue timeout (illegal-instruction detection) under PCPI_INITIATOR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for an offer
// ISSUE | pcpi.valid high, waiting for pcpi.ready (or timeout)
// DONE  | rsp_valid pulse, pcpi.valid low for one cycle
module pcpi_initiator
    import m_ext_pkg::*;
#(
    parameter int XLEN           = m_ext_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    output logic            rsp_wr,
    output logic [XLEN-1:0] rsp_rd,
    output logic            rsp_illegal,
    PCP.Master              pcpi
);
    pcpi_init_state_t state, state_nxt;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] rd_q;
    logic            wr_q;
    logic            accept;
    logic            in_issue;
    logic            timeout;

    assign req_ready        = (state == IDLE);
    assign accept           = req_valid && req_ready;
    assign in_issue         = (state == ISSUE);
    assign rsp_valid        = (state == DONE);
    assign pcpi.valid       = in_issue;
    assign pcpi.instruction = instr_q;
    assign pcpi.rs1         = rs1_q;
    assign pcpi.rs2         = rs2_q;
    assign rsp_rd           = rd_q;
    assign rsp_wr           = wr_q;

`ifdef PCPI_INITIATOR_TIMEOUT_EN
    logic busy_seen;
    logic illegal_q;

    pcpi_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (accept),
        .count_en (in_issue && !busy_seen && !pcpi.busy),
        .expired  (timeout)
    );

    // Once a coprocessor has claimed the instruction it may take as long as it likes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_seen <= 1'b0;
        end else if (accept) begin
            busy_seen <= 1'b0;
        end else if (in_issue && pcpi.busy) begin
            busy_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_q <= 1'b0;
        end else if (in_issue && pcpi.ready) begin
            illegal_q <= 1'b0;
        end else if (in_issue && timeout) begin
            illegal_q <= 1'b1;
        end
    end

    assign rsp_illegal = illegal_q;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign rsp_illegal        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) ^ pcpi.busy;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = ISSUE;
            ISSUE:   if (pcpi.ready || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            if (accept) begin
                instr_q <= req_instr;
                rs1_q   <= req_rs1;
                rs2_q   <= req_rs2;
            end
            // Ready takes priority over a coincident timeout.
            if (in_issue && pcpi.ready) begin
                rd_q <= pcpi.rd;
                wr_q <= pcpi.wr;
            end else if (in_issue && timeout) begin
                rd_q <= '0;
                wr_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pcpi_initiator.sv
// Self-checking bench for pcpi_initiator with a behavioural M-extension coprocessor.
module tb_pcpi_initiator;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_illegal;

    always #5 clk = ~clk;

    PCP #(.XLEN(32)) pcpi_bus ();

    pcpi_initiator #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr   (req_instr),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .rsp_valid   (rsp_valid),
        .rsp_wr      (rsp_wr),
        .rsp_rd      (rsp_rd),
        .rsp_illegal (rsp_illegal),
        .pcpi        (pcpi_bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int rsp_pulses = 0;
    int exp_pulses = 0;

    int cp_latency  = 2;
    bit cp_quiet    = 1'b0;
    bit cp_spurious = 1'b0;
    int cp_cnt      = 0;
    bit cp_active   = 1'b0;
    bit cp_fin      = 1'b0;

    bit          r_got;
    logic [31:0] r_rd;
    logic        r_wr;
    logic        r_ill;
    int          r_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension results from plain arithmetic.
    function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] mk_m(input logic [2:0] f3);
        logic [31:0] w;
        w = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
        return w;
    endfunction

    // Coprocessor model: claims M-type R instructions, busy for cp_latency cycles, then one ready pulse.
    always @(negedge clk) begin
        pcpi_bus.ready = 1'b0;
        pcpi_bus.rd    = $urandom;
        pcpi_bus.wr    = 1'($urandom_range(0, 1));
        if (pcpi_bus.valid !== 1'b1) begin
            cp_active     = 1'b0;
            cp_fin        = 1'b0;
            pcpi_bus.busy = 1'b0;
            pcpi_bus.ready = cp_spurious;
        end else if (cp_fin) begin
            pcpi_bus.busy = 1'b0;
        end else if (pcpi_bus.instruction[6:0] == 7'b0110011 &&
                     pcpi_bus.instruction[31:25] == 7'b0000001) begin
            if (!cp_active) begin
                cp_active = 1'b1;
                cp_cnt    = cp_latency;
            end else begin
                cp_cnt--;
            end
            if (cp_cnt == 0) begin
                pcpi_bus.ready = 1'b1;
                pcpi_bus.busy  = 1'b0;
                pcpi_bus.rd    = m_ref(pcpi_bus.instruction[14:12], pcpi_bus.rs1, pcpi_bus.rs2);
                pcpi_bus.wr    = 1'b1;
                cp_fin         = 1'b1;
            end else begin
                pcpi_bus.busy = !cp_quiet;
            end
        end else begin
            pcpi_bus.busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses++;
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b, input bit hold);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_instr = instr;
        req_rs1   = a;
        req_rs2   = b;
        for (int k = 0; k < 50; k++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        r_got    = 1'b0;
        r_cycles = 0;
        r_rd     = 'x;
        r_wr     = 1'bx;
        r_ill    = 1'bx;
        for (int k = 0; k < budget; k++) begin
            if (rsp_valid === 1'b1) begin
                r_got = 1'b1;
                r_rd  = rsp_rd;
                r_wr  = rsp_wr;
                r_ill = rsp_illegal;
                check("valid_low_in_done", 32'(pcpi_bus.valid), 32'd0);
                break;
            end
            if (pcpi_bus.valid === 1'b1) r_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic expect_m(input string tag, input logic [31:0] exp_rd, input int exp_cycles);
        check({tag, "_got"}, 32'(r_got), 32'd1);
        check({tag, "_rd"}, r_rd, exp_rd);
        check({tag, "_wr"}, 32'(r_wr), 32'd1);
        check({tag, "_ill"}, 32'(r_ill), 32'd0);
        check({tag, "_cycles"}, 32'(r_cycles), 32'(exp_cycles));
    endtask

    task automatic pulse_check(input string tag);
        @(negedge clk);
        check({tag, "_single_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_pulses"}, 32'(rsp_pulses), 32'(exp_pulses));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_instr = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rd", rsp_rd, 32'd0);
        check("rst_rsp_wr", 32'(rsp_wr), 32'd0);
        check("rst_rsp_ill", 32'(rsp_illegal), 32'd0);
        check("rst_pcpi_valid", 32'(pcpi_bus.valid), 32'd0);
        check("rst_pcpi_instr", pcpi_bus.instruction, 32'd0);
        check("rst_pcpi_rs1", pcpi_bus.rs1, 32'd0);
        check("rst_pcpi_rs2", pcpi_bus.rs2, 32'd0);
        resetn = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);

        // MUL 7*6 with short latency
        cp_latency = 2;
        issue(mk_m(3'd0), 32'd7, 32'd6, 1'b0);
        check("issue_instr", pcpi_bus.instruction, mk_m(3'd0));
        check("issue_rs1", pcpi_bus.rs1, 32'd7);
        wait_rsp(200);
        expect_m("mul", 32'd42, 3);
        exp_pulses++;
        pulse_check("mul");

        // Ready outside ISSUE must not disturb the held result
        cp_spurious = 1'b1;
        repeat (4) @(negedge clk);
        cp_spurious = 1'b0;
        @(negedge clk);
        check("hold_rd", rsp_rd, 32'd42);
        check("hold_wr", 32'(rsp_wr), 32'd1);
        check("spurious_pulses", 32'(rsp_pulses), 32'(exp_pulses));

        // DIV -20/3 with long busy period
        cp_latency = 36;
        issue(mk_m(3'd4), 32'hFFFF_FFEC, 32'd3, 1'b0);
        wait_rsp(200);
        expect_m("div", 32'hFFFF_FFFA, 37);
        exp_pulses++;
        pulse_check("div");

        // Non-M instruction with no responder
`ifdef PCPI_INITIATOR_TIMEOUT_EN
        issue({7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'd1, 32'd2, 1'b0);
        wait_rsp(200);
        check("illegal_got", 32'(r_got), 32'd1);
        check("illegal_cycles", 32'(r_cycles), 32'd16);
        check("illegal_flag", 32'(r_ill), 32'd1);
        check("illegal_rd", r_rd, 32'd0);
        check("illegal_wr", 32'(r_wr), 32'd0);
        exp_pulses++;
        pulse_check("illegal");
        repeat (3) @(negedge clk);
        check("illegal_hold", 32'(rsp_illegal), 32'd1);

        // Quiet coprocessor: ready on the 16th cycle wins, on the 17th is too late
        cp_quiet   = 1'b1;
        cp_latency = 15;
        issue(mk_m(3'd0), 32'd9, 32'd9, 1'b0);
        wait_rsp(200);
        expect_m("coincide", 32'd81, 16);
        exp_pulses++;
        pulse_check("coincide");
        cp_latency = 16;
        issue(mk_m(3'd0), 32'd9, 32'd9, 1'b0);
        wait_rsp(200);
        check("late_ready_ill", 32'(r_ill), 32'd1);
        check("late_ready_cycles", 32'(r_cycles), 32'd16);
        exp_pulses++;
        pulse_check("late_ready");
        cp_quiet = 1'b0;
`else
        issue({7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 32'd1, 32'd2, 1'b0);
        wait_rsp(1000);
        check("no_timeout_got", 32'(r_got), 32'd0);
        check("no_timeout_valid", 32'(pcpi_bus.valid), 32'd1);
        check("no_timeout_ill", 32'(rsp_illegal), 32'd0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
`endif

        // Back-to-back MULHU then REMU with req_valid held
        cp_latency = 3;
        issue(mk_m(3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_rsp(200);
        expect_m("mulhu", 32'hFFFF_FFFE, 4);
        exp_pulses++;
        cp_latency = 1;
        issue(mk_m(3'd7), 32'd10, 32'd4, 1'b0);
        wait_rsp(200);
        expect_m("remu", 32'd2, 2);
        exp_pulses++;
        pulse_check("b2b");

        // Reset during DIV busy
        cp_latency = 36;
        issue(mk_m(3'd4), 32'hFFFF_FFEC, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(pcpi_bus.valid), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rd", rsp_rd, 32'd0);
        check("rst_mid_pulses", 32'(rsp_pulses), 32'(exp_pulses));
        cp_latency = 0;
        issue(mk_m(3'd0), 32'd3, 32'd5, 1'b0);
        wait_rsp(200);
        expect_m("mul_after_rst", 32'd15, 1);
        exp_pulses++;
        pulse_check("mul_after_rst");

        // Randomised M operations against the reference arithmetic
        for (int i = 0; i < 24; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            lat = $urandom_range(0, 30);
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            cp_latency = lat;
            issue(mk_m(f3), a, b, 1'b0);
            wait_rsp(200);
            expect_m("rand", m_ref(f3, a, b), lat + 1);
            exp_pulses++;
        end
        pulse_check("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pcpi_initiator.md
PCPI_INITIATOR -- requirements
Module: pcpi_initiator

Interface
REQ-001 SHALL have parameter XLEN, default m_ext_pkg::XLEN (32), datapath width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, issue cycles allowed without pcpi.busy/pcpi.ready before abort.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  core offers an instruction.
REQ-006 SHALL have port req_ready  output  1  initiator accepts an offer this cycle.
REQ-007 SHALL have port req_instr  input  32  instruction word.
REQ-008 SHALL have port req_rs1  input  XLEN  operand 1.
REQ-009 SHALL have port req_rs2  input  XLEN  operand 2.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_wr  output  1  coprocessor requested a write-back.
REQ-012 SHALL have port rsp_rd  output  XLEN  result.
REQ-013 SHALL have port rsp_illegal  output  1  no coprocessor claimed the instruction.
REQ-014 SHALL have port pcpi  PCP.Master  -  drives valid/instruction/rs1/rs2; samples wr/rd/busy/ready.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DONE (pcpi_init_state_t).
REQ-016 SHALL assert req_ready only in IDLE; accept is req_valid & req_ready at a rising edge.
REQ-017 SHALL on accept register req_instr/rs1/rs2 into pcpi.instruction/rs1/rs2 and enter ISSUE.
REQ-018 SHALL drive pcpi.valid = (state==ISSUE), a registered decode; instruction/rs1/rs2 stable throughout ISSUE.
REQ-019 SHALL in ISSUE, on sampling pcpi.ready=1 (including the first ISSUE cycle), capture pcpi.rd to rsp_rd and pcpi.wr to rsp_wr, clear rsp_illegal, and enter DONE.
REQ-020 SHALL keep a sticky busy_seen flag, set when pcpi.busy=1 in ISSUE, cleared on accept.
REQ-021 SHALL count ISSUE cycles with busy_seen=0 and pcpi.busy=0; on reaching TIMEOUT_CYCLES without ready, set rsp_illegal=1, rsp_wr=0, rsp_rd=0, enter DONE.
REQ-022 SHALL never time out once busy_seen=1; wait for ready indefinitely.
REQ-023 SHALL, if ready and the timeout coincide in the same cycle, let ready win (normal completion).
REQ-024 SHALL in DONE assert rsp_valid for exactly one cycle with pcpi.valid=0, then return to IDLE unconditionally.
REQ-025 SHALL guarantee pcpi.valid low for ≥1 cycle between consecutive instructions (DONE cycle), so the coprocessor leaves FINISHED.
REQ-026 SHALL ignore pcpi.ready/busy outside ISSUE.
REQ-027 SHALL hold rsp_rd/rsp_wr/rsp_illegal stable until the next completion.

Reset
REQ-028 SHALL on resetn=0 force state=IDLE, pcpi.valid=0, pcpi.instruction/rs1/rs2=0, rsp_valid=0, rsp_wr=0, rsp_rd=0, rsp_illegal=0, counter=0, busy_seen=0.
REQ-029 SHALL, on reset mid-ISSUE, drop pcpi.valid immediately (asynchronously) and emit no rsp_valid.
REQ-030 SHALL drive req_ready=1 on the first cycle after reset release.

Configuration
REQ-031 SHALL honour macro PCPI_INITIATOR_TIMEOUT_EN: defined -> REQ-020..023 active; undefined -> no counter/flag synthesized, ISSUE waits for ready forever, rsp_illegal tied 0.

Structure
REQ-032 SHALL place pcpi_init_state_t and PCPI_TIMEOUT_CYCLES_DEFAULT in m_ext_pkg alongside XLEN.
REQ-033 SHALL place the timeout counter in sub-module pcpi_watchdog (inputs clk, resetn, clear, count_en; output expired), instantiated only under PCPI_INITIATOR_TIMEOUT_EN.

Verification
REQ-034 SHALL cover: MUL rs1=7 rs2=6 against M-extension coprocessor -> rsp_valid once, rsp_rd=42, rsp_wr=1, rsp_illegal=0, pcpi.valid low in DONE.
REQ-035 SHALL cover: DIV rs1=-20 (0xFFFFFFEC) rs2=3 -> busy held many cycles, no timeout, rsp_rd=0xFFFFFFFA.
REQ-036 SHALL cover: non-M instruction (func7≠0000001) with no responder -> after exactly 16 ISSUE cycles rsp_valid=1, rsp_illegal=1, rsp_rd=0; with macro undefined -> no response after 1000 cycles.
REQ-037 SHALL cover: back-to-back MULHU 0xFFFFFFFF*0xFFFFFFFF then REMU 10%4 with req_valid held -> rsp_rd=0xFFFFFFFE then 2, pcpi.valid low ≥1 cycle between.
REQ-038 SHALL cover: resetn pulsed low during DIV busy -> pcpi.valid=0 same cycle, no rsp_valid; next MUL 3*5 -> 15.
